// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch_debounce channel conditioner.
package switch_debounce_pkg;

  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 1;

  // Width of the stability counter; a single cycle of debounce still needs one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: synchroniser chain, stability counter, clean level and
// rise/fall pulses. SWITCH_DEBOUNCE_TOGGLE_EN turns led into a press-toggled register.
module switch_debounce_ch
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch,
  output logic level,
  output logic rise,
  output logic fall,
  output logic led
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // NOTE: every register here uses <= so all stages sample pre-edge values;
  // the sync chain is reset too, so no stale input leaks out after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], switch};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        // Stable long enough: accept and flag the direction in the same edge.
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end
    end
  end

`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 1'b0;
    end else if (r_rise) begin
      r_led <= ~r_led;
    end
  end

  assign led = r_led;
`else
  assign led = r_level;
`endif

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner: fans switch bits out to independent
// switch_debounce_ch instances. Optional feature macro: SWITCH_DEBOUNCE_TOGGLE_EN.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] switch,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] led
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("switch_debounce: CHANNELS must be at least 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("switch_debounce: SYNC_STAGES below minimum");
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_debounce
    $error("switch_debounce: DEBOUNCE_CYCLES below minimum");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    switch_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .switch(switch[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .led   (led[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce (CHANNELS=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4); accept latency is 6 edges from a stable input.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] switch;
  logic [1:0] level, rise, fall, led;

  int n_tests = 0;
  int n_fail  = 0;

  switch_debounce #(
    .CHANNELS       (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .switch(switch),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .led   (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample 1 ns later; plain builds also verify led mirrors level.
  task automatic tick();
    @(posedge clk);
    #1;
`ifndef SWITCH_DEBOUNCE_TOGGLE_EN
    check("led_eq_level", led, level);
`endif
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int n_rise0, n_fall0, n_rise1, n_fall1;

  initial begin
    rst_n  = 1'b0;
    switch = 2'b11;

    // Reset holds everything at zero regardless of switch.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_level", level, 2'b00);
      check("rst_rise",  rise,  2'b00);
      check("rst_fall",  fall,  2'b00);
      check("rst_led",   led,   2'b00);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("rel_level", level, (i >= 6) ? 2'b11 : 2'b00);
      check("rel_rise",  rise,  (i == 6) ? 2'b11 : 2'b00);
    end
    switch = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("rel_fall_level", level, (i >= 6) ? 2'b00 : 2'b11);
      check("rel_fall", fall, (i == 6) ? 2'b11 : 2'b00);
    end

    // Single clean edge on channel 0, then release.
    switch = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("edge_level", level, (i >= 6) ? 2'b01 : 2'b00);
      check("edge_rise",  rise,  (i == 6) ? 2'b01 : 2'b00);
      check("edge_fall",  fall,  2'b00);
    end
    switch = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("edge_rel_level", level, (i >= 6) ? 2'b00 : 2'b01);
      check("edge_rel_fall",  fall,  (i == 6) ? 2'b01 : 2'b00);
      check("edge_rel_rise",  rise,  2'b00);
    end

    // Glitch of 3 cycles on channel 1 is rejected.
    switch = 2'b10;
    ticks(3);
    switch = 2'b00;
    n_rise1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rise[1]) n_rise1++;
      check("glitch_level", level, 2'b00);
    end
    check("glitch_rise_cnt", n_rise1, 0);

    // 4-cycle pulse is just long enough: accepted, then released.
    switch  = 2'b10;
    n_rise1 = 0;
    n_fall1 = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 4) switch = 2'b00;
      if (rise[1]) n_rise1++;
      if (fall[1]) n_fall1++;
      if (i == 5) check("pulse4_level_e5", level, 2'b00);
      if (i == 6) check("pulse4_level_e6", level, 2'b10);
      if (i == 6) check("pulse4_rise_e6",  rise,  2'b10);
    end
    check("pulse4_rise_cnt", n_rise1, 1);
    check("pulse4_fall_cnt", n_fall1, 1);
    check("pulse4_level_end", level, 2'b00);

    // Bounce 1,0,1,1,0,1 then held 1 on channel 0.
    n_rise0 = 0;
    n_fall0 = 0;
    for (int i = 1; i <= 20; i++) begin
      case (i)
        1, 3, 4, 6: switch = 2'b01;
        2, 5:       switch = 2'b00;
        default:    switch = 2'b01;
      endcase
      tick();
      if (rise[0]) n_rise0++;
      if (fall[0]) n_fall0++;
      if (i == 10) check("bounce_level_e10", level, 2'b00);
      if (i == 11) check("bounce_level_e11", level, 2'b01);
    end
    check("bounce_rise_cnt", n_rise0, 1);
    check("bounce_fall_cnt", n_fall0, 0);

    // Reset clears outputs without waiting for a clock edge.
    rst_n = 1'b0;
    #2;
    check("async_rst_level", level, 2'b00);
    check("async_rst_led",   led,   2'b00);
    switch = 2'b00;
    tick();
    rst_n = 1'b1;
    ticks(8);
    check("post_rst_level", level, 2'b00);

    // Reset mid-count: cnt=2 after edge 4, then full latency after release.
    switch = 2'b01;
    ticks(4);
    rst_n = 1'b0;
    #2;
    check("midcnt_level", level, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midcnt_hold_level", level, 2'b00);
      check("midcnt_hold_rise",  rise,  2'b00);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("midcnt_rel_level", level, (i >= 6) ? 2'b01 : 2'b00);
      check("midcnt_rel_rise",  rise,  (i == 6) ? 2'b01 : 2'b00);
    end

    // Two clean press/release cycles on channel 0 from a fresh reset.
    switch = 2'b00;
    rst_n  = 1'b0;
    ticks(2);
    rst_n   = 1'b1;
    ticks(2);
    n_rise0 = 0;
    for (int p = 0; p < 2; p++) begin
      switch = 2'b01;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (rise[0]) n_rise0++;
      end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      check("tog_led_press", led, (p == 0) ? 2'b01 : 2'b00);
`else
      check("tog_led_press", led, 2'b01);
`endif
      switch = 2'b00;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (rise[0]) n_rise0++;
      end
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      check("tog_led_release", led, (p == 0) ? 2'b01 : 2'b00);
`else
      check("tog_led_release", led, 2'b00);
`endif
    end
    check("tog_rise_cnt", n_rise0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Parametrised multi-channel switch conditioner for board-level slide switches and push buttons. Each channel synchronises its asynchronous input through a configurable flip-flop chain, debounces it with a per-channel stability counter, and produces a clean level plus single-cycle rise/fall pulses. It sits between the board switch pins and the LED/control logic, replacing raw two-flop synchronisers wherever bounce-free levels or edge events are needed.

## Interface
- CHANNELS, 2, number of independent switch channels (≥1)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (≥2)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a new level (≥1)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- switch  input  CHANNELS  raw asynchronous switch inputs
- level  output  CHANNELS  debounced switch level
- rise  output  CHANNELS  one-cycle pulse on each accepted 0→1 change of level
- fall  output  CHANNELS  one-cycle pulse on each accepted 1→0 change of level
- led  output  CHANNELS  LED drive (see Configuration)

## Operation
- Channels are fully independent; no cross-channel interaction.
- Sync chain: stage0 ← switch[i], stage k ← stage k-1; s = last stage. All stages reset to 0.
- Debounce per channel: register level[i], counter cnt (width max(1, $clog2(DEBOUNCE_CYCLES))), both reset 0.
  - s == level[i]: cnt ← 0.
  - s != level[i] and cnt != DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - s != level[i] and cnt == DEBOUNCE_CYCLES-1: level[i] ← s, cnt ← 0, rise[i] or fall[i] asserted next cycle per direction.
- A glitch on s shorter than DEBOUNCE_CYCLES cycles returns cnt to 0; no level change, no pulse.
- Counter never wraps; it is cleared on acceptance or on agreement.
- DEBOUNCE_CYCLES=1: level follows s with one cycle delay.
- rise/fall are registered, high for exactly one cycle, coincident with the cycle level first shows the new value; never both high on one channel.

## Timing
- Reset: level, rise, fall, led, cnt and all sync stages = 0 while rst_n low, regardless of switch.
- Latency: switch stable before clock edge 1 → level updates after edge SYNC_STAGES + DEBOUNCE_CYCLES.
- Reset asserted mid-count: all state cleared immediately; after release, full latency restarts.
- Minimum accepted pulse width at switch: DEBOUNCE_CYCLES cycles (±1 for sampling uncertainty).

## Configuration
- SWITCH_DEBOUNCE_TOGGLE_EN defined: led[i] is a register (reset 0) that toggles on every rise[i] cycle; turns push buttons into on/off switches.
- Not defined: led = level (combinational copy); no toggle register exists.

## Structure
- Package switch_debounce_pkg: function computing counter width from DEBOUNCE_CYCLES (minimum 1); parameter legality constants (min SYNC_STAGES = 2, min DEBOUNCE_CYCLES = 1).
- Sub-module switch_debounce_ch: one channel (sync chain, counter, level, rise/fall, optional toggle), instantiated CHANNELS times in a generate loop.
- Top level only fans out switch bits and concatenates outputs.

## Test plan
Defaults for all: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: switch=2'b11 held with rst_n low for 10 cycles → level=rise=fall=led=2'b00 throughout; after release level=2'b11 after exactly 6 edges.
- Single edge: switch[0] 0→1 held → level[0]=1 after edge 6, rise[0] high for that one cycle only; channel 1 outputs stay 0; later 1→0 → fall[0] single pulse after 6 edges.
- Glitch: switch[1] high for 3 cycles then low → level[1], rise[1] stay 0; high for 4 cycles → level[1]=1 with one rise[1] pulse.
- Bounce: switch[0] pattern 1,0,1,1,0,1 then held 1 → exactly one rise[0], zero fall[0], level[0]=1 after 6 edges from the last 0→1.
- Reset mid-count: switch[0]=1, pull rst_n low when cnt=2 → all outputs 0; release with switch still 1 → level[0]=1 after full 6 edges.
- Toggle: with SWITCH_DEBOUNCE_TOGGLE_EN, two clean press/release cycles on switch[0] → led[0] 0→1→0 with two rise pulses; without the macro, led equals level every cycle.
